// File: rtl/region_colour_sched_if.sv
// Request-port pair (A and B) carrying colour updates into region_colour_sched.
// Requesters drive the master side; the scheduler drives the ready returns.
interface region_colour_sched_if #(
  parameter int COLOUR_W = 12
);
  logic                a_valid_in;
  logic                a_ready_out;
  logic [3:0]          a_region_in;
  logic [COLOUR_W-1:0] a_colour_in;
  logic                b_valid_in;
  logic                b_ready_out;
  logic [3:0]          b_region_in;
  logic [COLOUR_W-1:0] b_colour_in;

  modport master (
    output a_valid_in, a_region_in, a_colour_in,
    output b_valid_in, b_region_in, b_colour_in,
    input  a_ready_out, b_ready_out
  );

  modport slave (
    input  a_valid_in, a_region_in, a_colour_in,
    input  b_valid_in, b_region_in, b_colour_in,
    output a_ready_out, b_ready_out
  );
endinterface

// File: rtl/region_colour_sched.sv
// Two-port colour-update arbiter with shadow/active banks committed on vsync falling edge.
// Optional per-region blinking is compiled in with `define REGION_BLINK_EN.
//
// state  | meaning
// IDLE   | accepting writes into the shadow bank, watching for vsync edge
// COMMIT | one cycle: shadow copied to active, requesters stalled
module region_colour_sched #(
  parameter int NUM_REGIONS  = 12,
  parameter int COLOUR_W     = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  region_colour_sched_if.slave            req,
  input  logic                            vs_in,
  input  logic [NUM_REGIONS-1:0]          blink_mask_in,
  input  logic                            err_clr_in,
  output logic [NUM_REGIONS*COLOUR_W-1:0] region_colour_out,
  output logic                            frame_commit_out,
  output logic                            err_out
);

  typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

  state_t              state_q;
  logic                ptr_q;
  logic                vs_q;
  logic                dirty_q;
  logic                commit_q;
  logic                err_q;
  logic [COLOUR_W-1:0] shadow_q [NUM_REGIONS];
  logic [COLOUR_W-1:0] active_q [NUM_REGIONS];

  logic                both_valid;
  logic                grant_a;
  logic                grant_b;
  logic                acc;
  logic                wr_ok;
  logic                vs_edge;
  logic [3:0]          acc_region;
  logic [COLOUR_W-1:0] acc_colour;

  // ptr_q = 0 favours A on contention, 1 favours B
  always_comb begin
    both_valid = req.a_valid_in & req.b_valid_in;
    grant_a    = (state_q == IDLE) & req.a_valid_in & (~req.b_valid_in | ~ptr_q);
    grant_b    = (state_q == IDLE) & req.b_valid_in & (~req.a_valid_in | ptr_q);
    acc        = grant_a | grant_b;
    acc_region = grant_b ? req.b_region_in : req.a_region_in;
    acc_colour = grant_b ? req.b_colour_in : req.a_colour_in;
    wr_ok      = acc & ({1'b0, acc_region} < 5'(NUM_REGIONS));
    vs_edge    = vs_q & ~vs_in;
  end

  assign req.a_ready_out = grant_a;
  assign req.b_ready_out = grant_b;
  assign frame_commit_out = commit_q;
  assign err_out          = err_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      vs_q     <= 1'b1;
      dirty_q  <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      vs_q <= vs_in;
      if (both_valid && state_q == IDLE) ptr_q <= ~ptr_q;
      if (acc && !wr_ok) err_q <= 1'b1;
      else if (err_clr_in) err_q <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (wr_ok && acc_region == 4'(i)) shadow_q[i] <= acc_colour;
      end
      case (state_q)
        IDLE: begin
          if (wr_ok) dirty_q <= 1'b1;
          if (vs_edge && (dirty_q || wr_ok)) begin
            state_q  <= COMMIT;
            commit_q <= 1'b1;
          end
        end
        COMMIT: begin
          // shadow already holds any write accepted alongside the vsync edge
          for (int i = 0; i < NUM_REGIONS; i++) active_q[i] <= shadow_q[i];
          dirty_q  <= 1'b0;
          commit_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REGION_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt_q;
  logic            phase_q;

  // counts every vsync edge, committed or not
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (vs_edge) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    region_colour_out = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      region_colour_out[i*COLOUR_W +: COLOUR_W] =
        (blink_mask_in[i] & ~phase_q) ? '0 : active_q[i];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (^blink_mask_in) ^ (BLINK_FRAMES == 0);

  always_comb begin
    region_colour_out = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      region_colour_out[i*COLOUR_W +: COLOUR_W] = active_q[i];
    end
  end
`endif

endmodule

// File: doc/region_colour_sched.md
# region_colour_sched

Arbitrates colour-update requests from two independent requesters (port A: processor GPIO path; port B: UART/button animation path) into a shadow bank of per-region colour registers. Commits the shadow bank to the active bank only at the start of vertical sync, so the VGA controller never shows a partially updated frame. Sits between the processor system's region-colour outputs and the VGA controller's region colour inputs.

## Interface
- NUM_REGIONS, 12, number of screen regions (1..16)
- COLOUR_W, 12, bits per colour (4:4:4 RGB)
- BLINK_FRAMES, 30, vsync edges per blink half-period (≥1; only with blink enabled)

- clk_in  input  1  system clock; all logic on its rising edge
- reset_in  input  1  asynchronous, active-low reset
- a_valid_in  input  1  port A write request
- a_ready_out  output  1  port A accepted this cycle
- a_region_in  input  4  port A target region index
- a_colour_in  input  COLOUR_W  port A colour
- b_valid_in / b_ready_out / b_region_in / b_colour_in  same as port A, for port B
- vs_in  input  1  VGA vertical sync, active-low pulse, synchronous to clk_in
- blink_mask_in  input  NUM_REGIONS  per-region blink enable
- err_clr_in  input  1  clears err_out
- region_colour_out  output  NUM_REGIONS*COLOUR_W  active bank; region i at bits [i*COLOUR_W +: COLOUR_W]
- frame_commit_out  output  1  one-cycle pulse in the commit cycle
- err_out  output  1  sticky: out-of-range region write seen

## Operation
- FSM states: IDLE, COMMIT. Reset → IDLE.
- Arbiter (IDLE only): one valid → granted. Both valid → port named by pointer granted; pointer then moves to the other port. Pointer resets to A, changes only on a both-valid grant.
- x_ready_out = (state==IDLE) & grant_x; combinational, never asserted without x_valid_in.
- Accepted write: region < NUM_REGIONS → shadow[region] <= colour, dirty <= 1. Region ≥ NUM_REGIONS → write dropped, err_out <= 1.
- vs_q registers vs_in (resets to 1). vsync edge = vs_q & ~vs_in.
- IDLE, edge, and (dirty or a write accepted in the same cycle) → COMMIT. Edge with no pending data → stay IDLE, no pulse.
- COMMIT (exactly one cycle): active <= shadow (includes the write accepted in the edge cycle), dirty <= 0, frame_commit_out = 1, both ready low, then → IDLE. A request held during COMMIT is served in the next cycle.
- Writes to the same region before a commit: the last accepted write wins.
- err_out: set takes priority over err_clr_in in the same cycle.

## Timing
- Reset values: shadow and active banks 0, region_colour_out 0, frame_commit_out 0, err_out 0, dirty 0, pointer A, ready outputs 0.
- Reset asserted mid-COMMIT: banks clear immediately, the pending commit is lost.
- Write-to-visible latency: the shadow updates at the accept edge. region_colour_out changes on the clock edge ending the COMMIT cycle, one cycle after the vsync edge is detected.
- Throughput: one write per cycle, except one stall cycle per commit.
- vs_in is synchronous to clk_in; the block adds no synchronizer.

## Configuration
- REGION_BLINK_EN defined:
  - Frame counter (0..BLINK_FRAMES-1) counts every vsync edge, committed or not.
  - On wrap, phase toggles. Phase resets to 1 (on) and the counter resets to 0.
  - Region i outputs 0 when blink_mask_in[i] & ~phase, otherwise its active colour. The gating is combinational on the registered phase.
- REGION_BLINK_EN undefined: no counter or phase logic. blink_mask_in is ignored, and region_colour_out equals the active bank.

## Test plan
- Reset, then A writes region 3 = 0xF00 with no vsync → region_colour_out all 0, frame_commit_out never asserted.
- A writes region 3 = 0xF00, then vs_in falls → frame_commit_out pulses once, and bits [47:36] = 0xF00 one cycle after the edge. A second vsync with no writes gives no pulse.
- A and B both valid for 4 cycles (regions 0 and 1) → grants alternate A,B,A,B. After commit, region 0 and region 1 each hold their port's last colour.
- A writes region 12 = 0xABC → a_ready_out is 1, the bank is unchanged and err_out = 1. err_clr_in returns err_out to 0.
- A write coincides with the vsync edge → included in that commit. A request during COMMIT sees ready 0, then is accepted the next cycle and held for the next frame.
- With REGION_BLINK_EN, BLINK_FRAMES = 2, mask bit 5 set, region 5 = 0x0F0 → the output reads 0x0F0 for 2 vsyncs, then 0x000 for 2 vsyncs. Unmasked regions stay steady throughout.
